// File: rtl/hamming_secded_encoder.sv
// Hamming SEC / SEC-DED encoder with a 2-entry output buffer,
// per-word bit-flip injection and a delivered-word counter.
module hamming_secded_encoder #(
    parameter int DATA_W = 8,
    parameter int SECDED = 1,
    parameter int CNT_W  = 16,
    localparam int R = (DATA_W <= 4)  ? 3 :
                       (DATA_W <= 11) ? 4 :
                       (DATA_W <= 26) ? 5 : 6,
    localparam int CW_W = DATA_W + R + SECDED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_en,
    input  logic [5:0]        inj_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   hc_out,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int N = DATA_W + R;
    localparam logic [DATA_W-1:0] D_ONE  = DATA_W'(1);
    localparam logic [CW_W-1:0]   CW_ONE = CW_W'(1);
    localparam logic [6:0]        CW7    = 7'(CW_W);

    // Codeword position (1-based) of data bit idx: the idx-th non-power-of-two.
    function automatic int data_pos(int idx);
        int res;
        int n;
        res = 0;
        n = 0;
        for (int p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx && res == 0) res = p;
                n++;
            end
        end
        return res;
    endfunction

    // Data bits whose codeword position has bit k set.
    function automatic logic [DATA_W-1:0] dmask(int k);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (((data_pos(i) >> k) & 1) == 1) m = m | (D_ONE << i);
        end
        return m;
    endfunction

    logic [N-1:0]    code_raw;
    logic [CW_W-1:0] code;
    logic [CW_W-1:0] code_inj;
    logic            inj_hit;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
        localparam int P = data_pos(gi);
        assign code_raw[P-1] = in_data[gi];
    end

    for (genvar gk = 0; gk < R; gk++) begin : g_par
        localparam logic [DATA_W-1:0] M = dmask(gk);
        assign code_raw[(1 << gk) - 1] = ^(in_data & M);
    end

    if (SECDED != 0) begin : g_sd
        assign code = {^code_raw, code_raw};
    end else begin : g_sec
        assign code = code_raw;
    end

    assign inj_hit  = inj_en && ({1'b0, inj_pos} < CW7);
    assign code_inj = inj_hit ? (code ^ (CW_ONE << inj_pos)) : code;

    logic [CW_W-1:0]  head_q, head_d;
    logic [CW_W-1:0]  tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             rdy_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    assign push      = in_valid && rdy_q;
    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign in_ready  = rdy_q;
    assign hc_out    = head_q;
    assign word_cnt  = cnt_q;

    // Next-state of the 2-entry buffer; head_q is the visible output.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        cnt_d  = pop ? cnt_q + CNT_W'(1) : cnt_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = code_inj;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = code_inj;
                end else if (push) begin
                    tail_d = code_inj;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end
            end
        endcase
    end

    // Buffer, counter and registered in_ready update.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
            rdy_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            rdy_q  <= (occ_d != 2'd2);
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hamming_secded_encoder.sv
// Bench for hamming_secded_encoder: three configurations driven in
// lockstep, checked against a queue-based reference model.
module tb_hamming_secded_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       inj_en;
    logic [5:0] inj_pos;
    logic       out_ready;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [11:0] hc0;
    logic [12:0] hc1;
    logic [7:0]  hc2;
    logic [15:0] wc0;
    logic [3:0]  wc1;
    logic [15:0] wc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_secded_encoder #(.DATA_W(8), .SECDED(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .inj_en(inj_en), .inj_pos(inj_pos),
        .out_valid(ov0), .out_ready(out_ready), .hc_out(hc0), .word_cnt(wc0)
    );

    hamming_secded_encoder #(.DATA_W(8), .SECDED(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .inj_en(inj_en), .inj_pos(inj_pos),
        .out_valid(ov1), .out_ready(out_ready), .hc_out(hc1), .word_cnt(wc1)
    );

    hamming_secded_encoder #(.DATA_W(4), .SECDED(1), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data[3:0]), .inj_en(inj_en), .inj_pos(inj_pos),
        .out_valid(ov2), .out_ready(out_ready), .hc_out(hc2), .word_cnt(wc2)
    );

    // Reference: place data at non-power-of-two positions, then set each
    // parity bit so its covered positions XOR to zero; optional overall bit.
    function automatic int calc_r(int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    function automatic logic [63:0] ref_enc(int dw, int sd, logic [63:0] d,
                                            logic ie, logic [5:0] ip);
        int r;
        int n;
        int j;
        logic [63:0] cw;
        logic [63:0] mask;
        r  = calc_r(dw);
        n  = dw + r;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos <= n; pos++) begin
            if ($countones(pos) != 1) begin
                cw = cw | (((d >> j) & 64'd1) << (pos - 1));
                j++;
            end
        end
        for (int k = 0; k < r; k++) begin
            mask = '0;
            for (int pos = 1; pos <= n; pos++)
                if ((pos & (1 << k)) != 0) mask = mask | (64'd1 << (pos - 1));
            if (^(cw & mask)) cw = cw | (64'd1 << ((1 << k) - 1));
        end
        if (sd != 0 && (^cw)) cw = cw | (64'd1 << n);
        if (ie && (int'(ip) < n + sd)) cw = cw ^ (64'd1 << ip);
        return cw;
    endfunction

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];
    logic [63:0] m_hc0, m_hc1, m_hc2;
    logic        m_rdy = 1'b0;
    int          m_cnt = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic r;
        logic acc;
        logic pop;
        r   = rst;
        acc = in_valid && m_rdy;
        pop = (q0.size() != 0) && out_ready;
        if (acc) begin
            q0.push_back(ref_enc(8, 0, 64'(in_data), inj_en, inj_pos));
            q1.push_back(ref_enc(8, 1, 64'(in_data), inj_en, inj_pos));
            q2.push_back(ref_enc(4, 1, 64'(in_data & 8'h0F), inj_en, inj_pos));
        end
        @(posedge clk);
        #1;
        if (r) begin
            q0.delete(); q1.delete(); q2.delete();
            m_hc0 = '0; m_hc1 = '0; m_hc2 = '0;
            m_rdy = 1'b0;
            m_cnt = 0;
        end else begin
            if (pop) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
                void'(q2.pop_front());
                m_cnt++;
            end
            if (!acc) begin
                // acc entries were queued before the edge; nothing to do
            end
            if (q0.size() != 0) begin
                m_hc0 = q0[0]; m_hc1 = q1[0]; m_hc2 = q2[0];
            end
            m_rdy = (q0.size() < 2);
        end
        chk("rdy0", 64'(rdy0), 64'(m_rdy));
        chk("rdy1", 64'(rdy1), 64'(m_rdy));
        chk("rdy2", 64'(rdy2), 64'(m_rdy));
        chk("ov0", 64'(ov0), 64'(q0.size() != 0));
        chk("ov1", 64'(ov1), 64'(q1.size() != 0));
        chk("ov2", 64'(ov2), 64'(q2.size() != 0));
        chk("hc0", 64'(hc0), m_hc0);
        chk("hc1", 64'(hc1), m_hc1);
        chk("hc2", 64'(hc2), m_hc2);
        chk("wc0", 64'(wc0), 64'(m_cnt % 65536));
        chk("wc1", 64'(wc1), 64'(m_cnt % 16));
        chk("wc2", 64'(wc2), 64'(m_cnt % 65536));
    endtask

    task automatic send(logic [7:0] d, logic ie, logic [5:0] ip);
        in_valid = 1'b1;
        in_data  = d;
        inj_en   = ie;
        inj_pos  = ip;
        cycle();
        in_valid = 1'b0;
        inj_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cycle();
        chk("rst_rdy", 64'(rdy0), 64'd0);
        chk("rst_hc", 64'(hc1), 64'd0);
        rst = 1'b0;
        cycle();
        chk("rdy_after_rst", 64'(rdy0), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        inj_en    = 1'b0;
        inj_pos   = '0;
        out_ready = 1'b0;
        m_hc0 = '0; m_hc1 = '0; m_hc2 = '0;

        do_reset();

        out_ready = 1'b1;
        send(8'hA5, 1'b0, 6'd0);
        chk("basic_a5", 64'(hc0), 64'hA27);
        chk("secded_a5", 64'(hc1), 64'h0A27);
        send(8'h00, 1'b0, 6'd0);
        chk("basic_00", 64'(hc0), 64'h000);
        send(8'h01, 1'b0, 6'd0);
        chk("basic_01", 64'(hc0), 64'h007);
        chk("secded_01", 64'(hc1), 64'h1007);
        send(8'hA5, 1'b1, 6'd4);
        chk("inj_pos4", 64'(hc1), 64'h0A37);
        send(8'hA5, 1'b1, 6'd13);
        chk("inj_pos13", 64'(hc1), 64'h0A27);
        send(8'hA5, 1'b0, 6'd4);
        chk("inj_clear", 64'(hc1), 64'h0A27);
        send(8'hFF, 1'b0, 6'd0);
        chk("dw4_ff", 64'(hc2), 64'hFF);
        cycle();
        chk("empty_ov", 64'(ov2), 64'd0);
        chk("empty_hold", 64'(hc2), 64'hFF);

        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        cycle();
        in_data = 8'h00;
        cycle();
        in_data = 8'h01;
        cycle();
        chk("bp_full", 64'(rdy0), 64'd0);
        chk("bp_hold", 64'(hc0), 64'hA27);
        out_ready = 1'b1;
        cycle();
        chk("bp_second", 64'(hc0), 64'h000);
        chk("bp_rdy_back", 64'(rdy0), 64'd1);
        cycle();
        chk("bp_third", 64'(hc0), 64'h007);
        in_valid = 1'b0;
        cycle();
        chk("bp_cnt", 64'(wc0), 64'd3);

        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(8'(i * 13), 1'b0, 6'd0);
        cycle();
        chk("wrap_cnt", 64'(wc1), 64'd1);

        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            inj_en    = ($urandom_range(0, 3) == 0);
            inj_pos   = 6'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
